// File: rtl/asic_readout_pkg.sv
// asic_readout_pkg: shared state encoding and word constants for the ASIC readout serializer.
package asic_readout_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int GAP_CYCLES_DEFAULT = 4;
    localparam logic [DATA_WIDTH-1:0] UNDERFLOW_FILL = '0;
    typedef enum logic [2:0] {IDLE, PREFETCH, LOAD, SHIFT, GAP} state_t;
endpackage

// File: rtl/asic_word_shifter.sv
// asic_word_shifter: 16-bit parallel-load, MSB-first shift register with a wrapping 4-bit bit counter.
module asic_word_shifter
    import asic_readout_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  msb,
    output logic                  last_bit,
    output logic [3:0]            bit_count
);
    logic [DATA_WIDTH-1:0] sr;
    always_ff @(posedge clk) begin
        if (rst) begin
            sr        <= '0;
            bit_count <= '0;
        end else if (load) begin
            sr        <= din;
            bit_count <= '0;
        end else if (shift) begin
            sr        <= {sr[DATA_WIDTH-2:0], 1'b0};
            bit_count <= bit_count + 1'b1;
        end
    end
    assign msb      = sr[DATA_WIDTH-1];
    assign last_bit = bit_count == 4'hF;
endmodule

// File: rtl/asic_readout_serializer.sv
// asic_readout_serializer: emulates the ASIC serial readout port, draining FIFO words MSB-first under active-low TransmitOn.
// ASIC_DOUT_INVERT_EN selects inverted line polarity with idle level 1; undefined gives true polarity with idle level 0.
module asic_readout_serializer
    import asic_readout_pkg::*;
#(
    parameter int COUNT_WIDTH = 12,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEFAULT
) (
    input  logic                   ReadClk,
    input  logic                   reset,
    input  logic                   StartReadout,
    input  logic [COUNT_WIDTH-1:0] WordCount,
    input  logic [DATA_WIDTH-1:0]  InternalFifoData,
    input  logic                   InternalFifoEmpty,
    output logic                   InternalFifoReadEn,
    output logic                   AsicDout,
    output logic                   TransmitOn,
    output logic                   Busy,
    output logic                   TransmitDone,
    output logic                   Underflow
);
`ifdef ASIC_DOUT_INVERT_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif
    localparam int GW = $clog2(GAP_CYCLES + 1);
    state_t                 state;
    logic [COUNT_WIDTH-1:0] words_left;
    logic [GW-1:0]          gap_cnt;
    logic                   fill_zero, req, load, msb, last_bit;
    logic [3:0]             bit_count;
    // Next-word fetch lands two cycles before the word boundary so the load is seamless.
    assign req = state == PREFETCH || (state == SHIFT && bit_count == 4'd14 && words_left > COUNT_WIDTH'(1));
    assign InternalFifoReadEn = req && !InternalFifoEmpty;
    assign load = state == LOAD || (state == SHIFT && last_bit && words_left != COUNT_WIDTH'(1));
    asic_word_shifter u_shifter (
        .clk       (ReadClk),
        .rst       (reset),
        .load      (load),
        .shift     (state == SHIFT),
        .din       (fill_zero ? UNDERFLOW_FILL : InternalFifoData),
        .msb       (msb),
        .last_bit  (last_bit),
        .bit_count (bit_count)
    );
    always_ff @(posedge ReadClk) begin
        if (reset) begin
            state        <= IDLE;
            words_left   <= '0;
            gap_cnt      <= '0;
            fill_zero    <= 1'b0;
            TransmitOn   <= 1'b1;
            AsicDout     <= INV;
            Busy         <= 1'b0;
            TransmitDone <= 1'b0;
            Underflow    <= 1'b0;
        end else begin
            // Line outputs are registered, so they trail the state by one cycle.
            TransmitOn   <= state != SHIFT;
            AsicDout     <= (state == SHIFT && msb) ^ INV;
            TransmitDone <= state == GAP && gap_cnt == '0;
            if (req) begin
                fill_zero <= InternalFifoEmpty;
                if (InternalFifoEmpty) Underflow <= 1'b1;
            end
            case (state)
                IDLE: if (StartReadout && WordCount != '0) begin
                    words_left <= WordCount;
                    Busy       <= 1'b1;
                    state      <= PREFETCH;
                end
                PREFETCH: state <= LOAD;
                LOAD:     state <= SHIFT;
                SHIFT: if (last_bit) begin
                    words_left <= words_left - 1'b1;
                    if (words_left == COUNT_WIDTH'(1)) begin
                        state   <= GAP;
                        gap_cnt <= '0;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_cnt == GW'(GAP_CYCLES)) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_asic_readout_serializer.sv
// tb_asic_readout_serializer: directed frames against a FIFO model and a word scoreboard.
module tb_asic_readout_serializer;
`ifdef ASIC_DOUT_INVERT_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif
    localparam int G = 4;
    logic        ReadClk = 1'b0;
    logic        reset, StartReadout, InternalFifoEmpty;
    logic [11:0] WordCount;
    logic [15:0] InternalFifoData;
    logic        InternalFifoReadEn, AsicDout, TransmitOn, Busy, TransmitDone, Underflow;
    logic [15:0] mem [64];
    int          wr_ptr = 0, rd_ptr = 0;
    logic [15:0] exp_q [$];
    int          checks = 0, failures = 0;

    asic_readout_serializer dut (
        .ReadClk            (ReadClk),
        .reset              (reset),
        .StartReadout       (StartReadout),
        .WordCount          (WordCount),
        .InternalFifoData   (InternalFifoData),
        .InternalFifoEmpty  (InternalFifoEmpty),
        .InternalFifoReadEn (InternalFifoReadEn),
        .AsicDout           (AsicDout),
        .TransmitOn         (TransmitOn),
        .Busy               (Busy),
        .TransmitDone       (TransmitDone),
        .Underflow          (Underflow)
    );

    always #5 ReadClk = ~ReadClk;
    assign InternalFifoEmpty = wr_ptr == rd_ptr;
    always @(posedge ReadClk) if (InternalFifoReadEn) begin
        InternalFifoData <= mem[rd_ptr % 64];
        rd_ptr <= rd_ptr + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] w, input bit expect_it);
        mem[wr_ptr % 64] = w;
        wr_ptr++;
        if (expect_it) exp_q.push_back(w);
    endtask

    // Runs one frame from a start pulse to Busy falling; indices count edges after the sampling edge.
    task automatic frame(input int n, input int nreads, input bit spurious);
        int first_low = -1, first_read = -1, done_idx = -1, busy_end = -1;
        int lows = 0, falls = 0, reads = 0, badpos = 0, dones = 0, bits = 0;
        logic prev_on = 1'b1, prev_rd = 1'b0;
        logic [15:0] w = '0;
        StartReadout = 1'b1;
        WordCount = 12'(n);
        for (int i = 0; i < 16 * n + 40; i++) begin
            @(posedge ReadClk);
            #1 StartReadout = spurious && i == 4;
            @(negedge ReadClk);
            if (InternalFifoReadEn) begin
                reads++;
                if (first_read < 0) first_read = i;
                if (prev_rd || i % 16 != 0 || i / 16 >= n) badpos++;
            end
            prev_rd = InternalFifoReadEn;
            if (TransmitDone) begin
                dones++;
                done_idx = i;
            end
            if (!TransmitOn) begin
                if (prev_on) falls++;
                if (first_low < 0) first_low = i;
                lows++;
                w = {w[14:0], AsicDout ^ INV};
                bits++;
                if (bits == 16) begin
                    if (exp_q.size() == 0) check("extra_word", 32'(w), 32'hFFFF_FFFF);
                    else check("word", 32'(w), 32'(exp_q.pop_front()));
                    bits = 0;
                end
            end
            prev_on = TransmitOn;
            if (!Busy) begin
                busy_end = i;
                break;
            end
        end
        check("frame_falls", falls, 1);
        check("frame_low_cycles", lows, 16 * n);
        check("first_low_edge", first_low, 3);
        check("done_edge", done_idx, 3 + 16 * n);
        check("done_count", dones, 1);
        check("read_count", reads, nreads);
        check("read_position", badpos, 0);
        check("first_read_edge", first_read, nreads > 0 ? 0 : -1);
        check("busy_end_edge", busy_end, 3 + 16 * n + G);
        check("words_left_in_sb", exp_q.size(), 0);
        check("idle_level", AsicDout, INV);
    endtask

    initial begin
        int reads, lows, dones, busy;
        reset = 1'b1;
        StartReadout = 1'b0;
        WordCount = '0;
        repeat (3) @(posedge ReadClk);
        #1 reset = 1'b0;
        @(negedge ReadClk);
        check("rst_transmit_on", TransmitOn, 1);
        check("rst_dout", AsicDout, INV);
        check("rst_read_en", InternalFifoReadEn, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", TransmitDone, 0);
        check("rst_underflow", Underflow, 0);

        push(16'hA5C3, 1);
        frame(1, 1, 0);

        push(16'h0001, 1);
        push(16'h8000, 1);
        push(16'hFFFF, 1);
        frame(3, 3, 1);
        check("no_underflow", Underflow, 0);

        // A zero-length request must not touch a non-empty FIFO.
        push(16'h1111, 0);
        StartReadout = 1'b1;
        WordCount = '0;
        reads = 0; lows = 0; dones = 0; busy = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge ReadClk);
            #1 StartReadout = 1'b0;
            @(negedge ReadClk);
            reads += int'(InternalFifoReadEn);
            lows += int'(!TransmitOn);
            dones += int'(TransmitDone);
            busy += int'(Busy);
        end
        check("zero_count_reads", reads, 0);
        check("zero_count_low", lows, 0);
        check("zero_count_done", dones, 0);
        check("zero_count_busy", busy, 0);
        wr_ptr = rd_ptr;

        push(16'h1234, 1);
        exp_q.push_back(16'h0000);
        frame(2, 1, 0);
        check("underflow_set", Underflow, 1);
        repeat (10) @(negedge ReadClk);
        check("underflow_held", Underflow, 1);

        push(16'hBEEF, 0);
        push(16'hCAFE, 0);
        StartReadout = 1'b1;
        WordCount = 12'd2;
        for (int i = 0; i <= 26; i++) begin
            @(posedge ReadClk);
            #1 StartReadout = 1'b0;
        end
        check("mid_frame_low", TransmitOn, 0);
        reset = 1'b1;
        @(posedge ReadClk);
        #1 reset = 1'b0;
        @(negedge ReadClk);
        check("midrst_transmit_on", TransmitOn, 1);
        check("midrst_busy", Busy, 0);
        check("midrst_underflow", Underflow, 0);
        check("midrst_dout", AsicDout, INV);
        check("midrst_done", TransmitDone, 0);
        wr_ptr = rd_ptr;

        push(16'h5A5A, 1);
        frame(1, 1, 0);
        check("after_rst_underflow", Underflow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
